uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered 8N1 UART transmitter; the transmit side of the terminal's UART link.
//   Bytes (echo, status, cursor reports) are written into an internal FIFO.
//   The bytes are serialised LSB-first on Tx_o at BAUD.
//   Complements the UartRx receive path; shares the same CLOCK_HZ/BAUD parameter set.
// PARAMETERS
//   CLOCK_HZ    10000000  system clock frequency, Hz
//   BAUD        115200    line rate, bit/s; CLOCKS_PER_BIT = CLOCK_HZ/BAUD (integer div, 86 at defaults)
//   FIFO_DEPTH  16        FIFO entries; power of 2, >=2; AW = $clog2(FIFO_DEPTH)
// PORTS
//   Clock    input   1     system clock, all logic on rising edge
//   Reset    input   1     asynchronous, active-low reset
//   Data_i   input   8     byte to enqueue
//   Write_i  input   1     enqueue strobe, one byte per cycle high
//   Full_o   output  1     FIFO holds FIFO_DEPTH bytes
//   Empty_o  output  1     FIFO holds 0 bytes
//   Count_o  output  AW+1  bytes currently in FIFO (excludes byte in shifter)
//   Busy_o   output  1     frame in progress (START/DATA/STOP)
//   Done_o   output  1     1-cycle pulse on last cycle of each stop bit
//   Tx_o     output  1     serial line, idle high
// BEHAVIOUR
//   Reset (Reset=0, async): Tx_o=1, Busy_o=0, Done_o=0, Full_o=0, Empty_o=1, Count_o=0.
//     Pointers, bit counter and baud counter are cleared; state is IDLE.
//     A frame in flight is abandoned and Tx_o returns high immediately.
//   FIFO: registered flags/count, updated on the edge after the write/pop.
//     Write_i while Full_o=1 -> byte dropped, no state change (this holds even if a pop occurs that cycle).
//     Write and pop in the same cycle (not full) -> Count_o unchanged, both take effect.
//     Pointers wrap modulo FIFO_DEPTH.
//   Baud counter: counts 0..CLOCKS_PER_BIT-1 within each bit and is cleared on every state change.
//     Every bit, including the stop bit, lasts exactly CLOCKS_PER_BIT cycles.
//   FSM:
//     IDLE : Tx_o=1. If Empty_o=0 -> pop the FIFO head into the shifter and go to START.
//     START: Tx_o=0 for one bit time -> DATA, bit index=0.
//     DATA : Tx_o=shifter[idx]. At end of bit: idx 7 -> STOP, else idx+1.
//     STOP : Tx_o=1 for one bit time. On its last cycle Done_o=1.
//            If Empty_o=0 -> pop and go directly to START (no extra idle cycle); else -> IDLE.
//   Latency: write at edge N into empty FIFO with FSM IDLE.
//     Empty_o=0 from N+1; pop at edge N+1; Tx_o=0 from N+2.
//   Frame length: 10*CLOCKS_PER_BIT cycles (860 at defaults); Busy_o high throughout.
//   Data_i is sampled only on write; the shifter is independent of later FIFO writes.
// TESTING
//   Reset released, no writes -> Tx_o=1, Empty_o=1, Busy_o=0 indefinitely.
//   Write 0x55 -> Tx_o low 2 cycles later; bits 1,0,1,0,1,0,1,0 then stop, each 86 cycles; Done_o one pulse at cycle 860 of frame.
//   Write 0xA3,0x0F back-to-back -> two frames contiguous (stop of 1st directly followed by start of 2nd); 2 Done_o pulses.
//   18 consecutive writes 0x00..0x11 from idle -> Full_o=1 after 17th; 0x11 dropped; 0x00..0x10 appear on Tx_o in order.
//   Reset asserted mid-DATA of 0xFF -> Tx_o=1 asynchronously, Count_o=0; after release no residual frame sent.
//   CLOCK_HZ=1000, BAUD=100 (10 cycles/bit) with FIFO_DEPTH=2 -> wrap-around over 5 bytes 0x01..0x05 written one per frame, all received correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Line outputs are registered so Tx_o, Busy_o and Done_o stay aligned.
module uart_tx_fifo #(
    parameter int CLOCK_HZ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [7:0]    Data_i,
    input  logic          Write_i,
    output logic          Full_o,
    output logic          Empty_o,
    output logic [AW:0]   Count_o,
    output logic          Busy_o,
    output logic          Done_o,
    output logic          Tx_o
);

    localparam int CPB = CLOCK_HZ / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST  = CW'(CPB - 1);
    localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nx;
    logic            wr_en;
    logic            pop;
    logic            bit_end;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shifter;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign wr_en   = Write_i & ~Full_o;
    assign bit_end = (baud_cnt == LAST);
    assign Count_o = count;

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= Data_i;
        end
    end

    // Occupancy after this cycle's write and pop
    always_comb begin
        count_nx = count;
        if (wr_en && !pop) begin
            count_nx = count + 1'b1;
        end else if (!wr_en && pop) begin
            count_nx = count - 1'b1;
        end
    end

    // Pointers, count and registered flags
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            Full_o  <= 1'b0;
            Empty_o <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nx;
            Full_o  <= (count_nx == DEPTH);
            Empty_o <= (count_nx == '0);
        end
    end

    // Next-state logic; a pop happens only when leaving IDLE or STOP
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!Empty_o) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!Empty_o) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, baud timing, bit index and shifter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (pop) begin
                shifter <= mem[rd_ptr];
            end
        end
    end

    // Registered line outputs; reset forces the line idle at once
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Tx_o   <= 1'b1;
            Busy_o <= 1'b0;
            Done_o <= 1'b0;
        end else begin
            case (state)
                START:   Tx_o <= 1'b0;
                DATA:    Tx_o <= shifter[bit_idx];
                default: Tx_o <= 1'b1;
            endcase
            Busy_o <= (state != IDLE);
            Done_o <= (state == STOP) && bit_end;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default rate DUT plus a
// 10-cycles-per-bit, depth-2 DUT for pointer wrap-around.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst1, rst2;
    logic [7:0] data1, data2;
    logic       wr1, wr2;
    logic       full1, empty1, busy1, done1, tx1;
    logic       full2, empty2, busy2, done2, tx2;
    logic [4:0] count1;
    logic [1:0] count2;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo u_dut1 (
        .Clock   (clk),
        .Reset   (rst1),
        .Data_i  (data1),
        .Write_i (wr1),
        .Full_o  (full1),
        .Empty_o (empty1),
        .Count_o (count1),
        .Busy_o  (busy1),
        .Done_o  (done1),
        .Tx_o    (tx1)
    );

    uart_tx_fifo #(
        .CLOCK_HZ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (2)
    ) u_dut2 (
        .Clock   (clk),
        .Reset   (rst2),
        .Data_i  (data2),
        .Write_i (wr2),
        .Full_o  (full2),
        .Empty_o (empty2),
        .Count_o (count2),
        .Busy_o  (busy2),
        .Done_o  (done2),
        .Tx_o    (tx2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write1(input logic [7:0] b);
        data1 = b;
        wr1   = 1'b1;
        tick();
        wr1   = 1'b0;
    endtask

    task automatic write2(input logic [7:0] b);
        data2 = b;
        wr2   = 1'b1;
        tick();
        wr2   = 1'b0;
    endtask

    task automatic idle_check(input bit which, input int n,
                              input string tag);
        int bad = 0;
        logic t, bz, d;
        repeat (n) begin
            t  = which ? tx2 : tx1;
            bz = which ? busy2 : busy1;
            d  = which ? done2 : done1;
            if (t !== 1'b1 || bz !== 1'b0 || d !== 1'b0) bad++;
            tick();
        end
        chk(tag, bad, 0);
    endtask

    // Walks frame cycles first_k..10*cpb, expected line built from the byte.
    task automatic check_frame(input bit which, input int cpb,
                               input logic [7:0] b, input int first_k,
                               input string tag);
        int bad_tx = 0;
        int bad_done = 0;
        int bad_busy = 0;
        int bit_no;
        logic [7:0] got = 8'h00;
        logic t, bz, d, e;
        for (int k = first_k; k <= 10 * cpb; k++) begin
            t  = which ? tx2 : tx1;
            bz = which ? busy2 : busy1;
            d  = which ? done2 : done1;
            bit_no = (k - 1) / cpb;
            if (bit_no == 0) e = 1'b0;
            else if (bit_no <= 8) e = b[bit_no-1];
            else e = 1'b1;
            if (t !== e) bad_tx++;
            if (d !== (k == 10 * cpb)) bad_done++;
            if (bz !== 1'b1) bad_busy++;
            if (bit_no >= 1 && bit_no <= 8 && ((k - 1) % cpb) == cpb / 2)
                got[bit_no-1] = t;
            tick();
        end
        chk({tag, "_tx"}, bad_tx, 0);
        chk({tag, "_done"}, bad_done, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_byte"}, got, b);
    endtask

    initial begin
        rst1  = 1'b0;
        rst2  = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;
        wr1   = 1'b0;
        wr2   = 1'b0;
        repeat (3) tick();

        chk("rst_tx", tx1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_full", full1, 0);
        chk("rst_empty", empty1, 1);
        chk("rst_count", count1, 0);
        chk("rst2_tx", tx2, 1);
        chk("rst2_empty", empty2, 1);
        rst1 = 1'b1;
        rst2 = 1'b1;
        idle_check(0, 200, "idle1");
        idle_check(1, 20, "idle2");
        chk("idle_empty", empty1, 1);

        write1(8'h55);
        chk("lat_empty", empty1, 0);
        chk("lat_count", count1, 1);
        chk("lat_tx_n1", tx1, 1);
        tick();
        chk("lat_pop_count", count1, 0);
        chk("lat_tx_n2", tx1, 1);
        tick();
        check_frame(0, 86, 8'h55, 1, "f55");
        idle_check(0, 50, "post55");

        data1 = 8'hA3;
        wr1   = 1'b1;
        tick();
        data1 = 8'h0F;
        tick();
        wr1   = 1'b0;
        chk("b2b_count", count1, 1);
        tick();
        check_frame(0, 86, 8'hA3, 1, "fA3");
        check_frame(0, 86, 8'h0F, 1, "f0F");
        idle_check(0, 50, "post0F");

        for (int i = 0; i < 18; i++) begin
            data1 = 8'(i);
            wr1   = 1'b1;
            tick();
            if (i == 15) chk("full_15", full1, 0);
            if (i == 16) begin
                chk("full_16", full1, 1);
                chk("count_16", count1, 16);
            end
        end
        wr1 = 1'b0;
        chk("full_drop", full1, 1);
        chk("count_drop", count1, 16);
        check_frame(0, 86, 8'h00, 16, "fill00");
        for (int j = 1; j <= 16; j++) begin
            check_frame(0, 86, 8'(j), 1, $sformatf("fill%02h", j));
        end
        idle_check(0, 200, "no_11");
        chk("fill_empty", empty1, 1);

        write1(8'hFF);
        write1(8'h12);
        write1(8'h34);
        repeat (300) tick();
        chk("mid_busy", busy1, 1);
        chk("mid_count", count1, 2);
        rst1 = 1'b0;
        #1;
        chk("arst_tx", tx1, 1);
        chk("arst_busy", busy1, 0);
        chk("arst_count", count1, 0);
        chk("arst_empty", empty1, 1);
        tick();
        rst1 = 1'b1;
        idle_check(0, 1000, "no_residual");
        chk("resid_empty", empty1, 1);

        write1(8'h00);
        repeat (20) tick();
        chk("start_low", tx1, 0);
        rst1 = 1'b0;
        #1;
        chk("arst_start_tx", tx1, 1);
        tick();
        rst1 = 1'b1;
        idle_check(0, 100, "post_arst");

        for (int i = 1; i <= 5; i++) begin
            write2(8'(i));
            tick();
            tick();
            check_frame(1, 10, 8'(i), 1, $sformatf("wrap%0d", i));
        end

        write2(8'h06);
        write2(8'h07);
        write2(8'h08);
        chk("d2_full", full2, 1);
        chk("d2_count", count2, 2);
        check_frame(1, 10, 8'h06, 1, "d2f06");
        check_frame(1, 10, 8'h07, 1, "d2f07");
        check_frame(1, 10, 8'h08, 1, "d2f08");
        idle_check(1, 50, "d2_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
